// File: rtl/vga_pattern_src.sv
// VGA-timed RGB565 pattern source.
// Stage 0 holds the h/v counters, stage 1 registers the ROM request plus the
// generated pattern and sync levels, stage 2 registers every video output.
// mem_rdata is sampled by the stage-2 register on the clock edge that ends the
// cycle in which mem_addr/mem_rd_en are presented.
module vga_pattern_src #(
   parameter int H_ACTIVE  = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_ACTIVE  = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33,
   parameter bit SYNC_POL  = 1'b0,
   parameter int IMG_W     = 128,
   parameter int IMG_H     = 128,
   parameter int ADDR_W    = 14,
   parameter int MEM_W     = 1,
   parameter int CHK_SHIFT = 3
) (
   input  logic              vga_clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [1:0]        mode,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [MEM_W-1:0]  mem_rdata,
   output logic              vga_hs,
   output logic              vga_vs,
   output logic              vga_de,
   output logic [11:0]       pix_x,
   output logic [11:0]       pix_y,
   output logic [15:0]       pix_rgb,
   output logic              frame_start,
   output logic [15:0]       frame_cnt
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
   localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
   localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
   localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
   localparam logic [11:0] HS_BEG   = 12'(H_ACTIVE + H_FP);
   localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [11:0] VS_BEG   = 12'(V_ACTIVE + V_FP);
   localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [11:0] IMG_W12  = 12'(IMG_W);
   localparam logic [11:0] IMG_H12  = 12'(IMG_H);
   localparam logic [11:0] BAR_LAST = 12'(H_ACTIVE / 8 - 1);
   localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);

   // RUN means a frame is in progress; IDLE waits for en at (0,0).
   typedef enum logic {S_IDLE, S_RUN} state_t;
   state_t state, state_nxt;

   logic [11:0]       h_cnt, v_cnt;
   logic [2:0]        bar_idx;
   logic [11:0]       bar_pos;
   logic [ADDR_W-1:0] row_base;
   logic [1:0]        mode_q;

   logic       cnt_act, line_end, frame_end, at_origin, in_img, rd_req;
   logic [1:0] mode_cur;
   logic       de0, hs_lvl, vs_lvl;
   logic [15:0] pat0, bar_rgb, rom_pix;

   logic        s1_de, s1_hs, s1_vs, s1_fs;
   logic [11:0] s1_x, s1_y;
   logic [1:0]  s1_mode;
   logic [15:0] s1_pat;

   // State register.
   always_ff @(posedge vga_clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Counters advance while a frame runs or en requests one; the last pixel of
   // a frame always returns to IDLE so en is re-examined at (0,0).
   always_comb begin
      cnt_act   = (state == S_RUN) || en;
      line_end  = (h_cnt == H_LAST);
      frame_end = line_end && (v_cnt == V_LAST);
      at_origin = (h_cnt == 12'd0) && (v_cnt == 12'd0);
      state_nxt = state;
      if (cnt_act) state_nxt = frame_end ? S_IDLE : S_RUN;
   end

   // Stage 0: pixel counters, bar tracker, ROM row base and mode latch.
   always_ff @(posedge vga_clk or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt    <= '0;
         v_cnt    <= '0;
         bar_idx  <= '0;
         bar_pos  <= '0;
         row_base <= '0;
         mode_q   <= '0;
      end else if (cnt_act) begin
         if (at_origin) mode_q <= mode;
         if (line_end) begin
            h_cnt   <= '0;
            bar_idx <= '0;
            bar_pos <= '0;
            if (frame_end) begin
               v_cnt    <= '0;
               row_base <= '0;
            end else begin
               v_cnt <= v_cnt + 12'd1;
               if (v_cnt < IMG_H12) row_base <= row_base + ROW_STEP;
            end
         end else begin
            h_cnt <= h_cnt + 12'd1;
            // Bar 7 absorbs any remainder columns, so it never advances.
            if ((bar_idx != 3'd7) && (bar_pos == BAR_LAST)) begin
               bar_idx <= bar_idx + 3'd1;
               bar_pos <= '0;
            end else begin
               bar_pos <= bar_pos + 12'd1;
            end
         end
      end
   end

   // Pattern, sync and ROM request for the pixel at the counters.
   always_comb begin
      mode_cur = at_origin ? mode : mode_q;
      in_img   = (h_cnt < IMG_W12) && (v_cnt < IMG_H12);
      rd_req   = cnt_act && (mode_cur == 2'd0) && in_img;
      de0      = cnt_act && (h_cnt < H_ACT) && (v_cnt < V_ACT);
      hs_lvl   = (cnt_act && (h_cnt >= HS_BEG) && (h_cnt < HS_END)) ? SYNC_POL : ~SYNC_POL;
      vs_lvl   = (cnt_act && (v_cnt >= VS_BEG) && (v_cnt < VS_END)) ? SYNC_POL : ~SYNC_POL;
      case (bar_idx)
         3'd0:    bar_rgb = 16'hFFFF;
         3'd1:    bar_rgb = 16'hFFE0;
         3'd2:    bar_rgb = 16'h07FF;
         3'd3:    bar_rgb = 16'h07E0;
         3'd4:    bar_rgb = 16'hF81F;
         3'd5:    bar_rgb = 16'hF800;
         3'd6:    bar_rgb = 16'h001F;
         default: bar_rgb = 16'h0000;
      endcase
      case (mode_cur)
         2'd1:    pat0 = bar_rgb;
         2'd2:    pat0 = (h_cnt[CHK_SHIFT] ^ v_cnt[CHK_SHIFT]) ? 16'hFFFF : 16'h0000;
         2'd3:    pat0 = {h_cnt[7:3], h_cnt[7:2], h_cnt[7:3]};
         default: pat0 = 16'h0000;
      endcase
   end

   // Stage 1: ROM request and pattern/sync registered.
   always_ff @(posedge vga_clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_rd_en <= 1'b0;
         mem_addr  <= '0;
         s1_de     <= 1'b0;
         s1_hs     <= ~SYNC_POL;
         s1_vs     <= ~SYNC_POL;
         s1_fs     <= 1'b0;
         s1_x      <= '0;
         s1_y      <= '0;
         s1_mode   <= '0;
         s1_pat    <= '0;
      end else begin
         mem_rd_en <= rd_req;
         mem_addr  <= rd_req ? (row_base + ADDR_W'(h_cnt)) : '0;
         s1_de     <= de0;
         s1_hs     <= hs_lvl;
         s1_vs     <= vs_lvl;
         s1_fs     <= cnt_act && at_origin;
         s1_x      <= h_cnt;
         s1_y      <= v_cnt;
         s1_mode   <= mode_cur;
         s1_pat    <= pat0;
      end
   end

   // ROM word to RGB565: a binary image expands to white/black.
   always_comb begin
      rom_pix = (MEM_W == 1) ? {16{mem_rdata[0]}} : 16'(mem_rdata);
   end

   // Stage 2: registered video outputs, blanked outside the active area.
   always_ff @(posedge vga_clk or negedge rst_n) begin
      if (!rst_n) begin
         vga_hs      <= ~SYNC_POL;
         vga_vs      <= ~SYNC_POL;
         vga_de      <= 1'b0;
         pix_x       <= '0;
         pix_y       <= '0;
         pix_rgb     <= '0;
         frame_start <= 1'b0;
         frame_cnt   <= '0;
      end else begin
         vga_hs      <= s1_hs;
         vga_vs      <= s1_vs;
         vga_de      <= s1_de;
         pix_x       <= s1_x;
         pix_y       <= s1_y;
         frame_start <= s1_fs;
         if (s1_fs) frame_cnt <= frame_cnt + 16'd1;
         if (!s1_de)                pix_rgb <= 16'h0000;
         else if (s1_mode == 2'd0)  pix_rgb <= mem_rd_en ? rom_pix : 16'h0000;
         else                       pix_rgb <= s1_pat;
      end
   end

endmodule

// File: tb/tb_vga_pattern_src.sv
// Directed bench for vga_pattern_src on a small 40x12 raster with a 4x4
// diagonal binary image in the ROM.
module tb_vga_pattern_src;

   logic        vga_clk;
   logic        rst_n;
   logic        en;
   logic [1:0]  mode;
   logic        mem_rd_en;
   logic [3:0]  mem_addr;
   logic [0:0]  mem_rdata;
   logic        vga_hs, vga_vs, vga_de;
   logic [11:0] pix_x, pix_y;
   logic [15:0] pix_rgb;
   logic        frame_start;
   logic [15:0] frame_cnt;

   int n_tests = 0;
   int n_fail  = 0;
   int n_de, n_hs, n_vs, n_fs;

   logic [15:0] rom_bits;
   logic [15:0] bars [8];

   vga_pattern_src #(
      .H_ACTIVE(32), .H_FP(2), .H_SYNC(4), .H_BP(2),
      .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .SYNC_POL(1'b0), .IMG_W(4), .IMG_H(4), .ADDR_W(4), .MEM_W(1), .CHK_SHIFT(3)
   ) dut (
      .vga_clk(vga_clk), .rst_n(rst_n), .en(en), .mode(mode),
      .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de),
      .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
      .frame_start(frame_start), .frame_cnt(frame_cnt)
   );

   // Clock.
   initial vga_clk = 1'b0;
   always #5 vga_clk = ~vga_clk;

   // ROM model: the word for the presented address, sampled at the next edge.
   assign mem_rdata = mem_rd_en & rom_bits[mem_addr];

   // Safety net against a stuck simulation.
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   initial begin
      rom_bits = 16'b1000_0100_0010_0001;   // addresses 0, 5, 10, 15
      bars[0] = 16'hFFFF; bars[1] = 16'hFFE0; bars[2] = 16'h07FF; bars[3] = 16'h07E0;
      bars[4] = 16'hF81F; bars[5] = 16'hF800; bars[6] = 16'h001F; bars[7] = 16'h0000;

      // Reset state.
      rst_n = 1'b0; en = 1'b0; mode = 2'd2;
      repeat (3) @(negedge vga_clk);
      check("rst_hs", vga_hs, 1);
      check("rst_vs", vga_vs, 1);
      check("rst_de", vga_de, 0);
      check("rst_rgb", pix_rgb, 0);
      check("rst_fcnt", frame_cnt, 0);
      check("rst_rd", mem_rd_en, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_fs", frame_start, 0);

      // Timing frame, checkerboard.
      en = 1'b1; rst_n = 1'b1;
      @(negedge vga_clk);
      check("start_fs_early", frame_start, 0);
      @(negedge vga_clk);
      check("start_fs", frame_start, 1);
      check("start_fcnt", frame_cnt, 1);
      check("start_de", vga_de, 1);
      n_de = 0; n_hs = 0; n_vs = 0;
      for (int i = 0; i < 480; i++) begin
         if (vga_de)  n_de++;
         if (!vga_hs) n_hs++;
         if (!vga_vs) n_vs++;
         if (i == 8)   check("chk_x8_y0", pix_rgb, 16'hFFFF);
         if (i == 48)  check("chk_x8_y1", pix_rgb, 16'hFFFF);
         if (i == 33)  check("de_off_x33", vga_de, 0);
         if (i == 33)  check("blank_rgb", pix_rgb, 0);
         if (i == 34)  check("hs_begin", vga_hs, 0);
         if (i == 37)  check("hs_last", vga_hs, 0);
         if (i == 38)  check("hs_end", vga_hs, 1);
         if (i == 40)  check("line1_y", pix_y, 1);
         if (i == 320) check("de_off_y8", vga_de, 0);
         if (i == 360) check("vs_begin", vga_vs, 0);
         if (i == 440) check("vs_end", vga_vs, 1);
         if (i == 100) mode = 2'd0;
         @(negedge vga_clk);
      end
      check("frame_period_fs", frame_start, 1);
      check("fcnt_2", frame_cnt, 2);
      check("de_count", n_de, 256);
      check("hs_low_count", n_hs, 48);
      check("vs_low_count", n_vs, 80);

      // ROM frame, diagonal binary image.
      for (int i = 0; i < 480; i++) begin
         if ((i % 40) < 4 && (i / 40) < 4)
            check("rom_px", pix_rgb, ((i % 40) == (i / 40)) ? 16'hFFFF : 16'h0000);
         if (i == 3)  check("rd_off_x4", mem_rd_en, 0);
         if (i == 40) check("addr_5", mem_addr, 5);
         if (i == 40) check("rd_5", mem_rd_en, 1);
         if (i == 45) check("rom_out_img", pix_rgb, 0);
         if (i == 100) mode = 2'd1;
         @(negedge vga_clk);
      end
      check("rom_end_fs", frame_start, 1);
      check("fcnt_3", frame_cnt, 3);

      // Colour bar frame; mode 3 requested mid-frame.
      for (int i = 0; i < 480; i++) begin
         if (i < 40) check("bar_line0", pix_rgb, (i < 32) ? bars[i / 4] : 16'h0000);
         if (i == 45)  check("bar_x5_y1", pix_rgb, 16'hFFE0);
         if (i == 100) mode = 2'd3;
         if (i == 208) check("bar_after_change", pix_rgb, 16'h07FF);
         if (i == 320) check("bar_blank_y8", pix_rgb, 0);
         @(negedge vga_clk);
      end
      check("bar_end_fs", frame_start, 1);
      check("fcnt_4", frame_cnt, 4);

      // Grey ramp frame, interrupted by reset mid-line.
      for (int i = 0; i < 53; i++) begin
         if (i == 5)  check("grey_x5", pix_rgb, 16'h0020);
         if (i == 8)  check("grey_x8", pix_rgb, 16'h0841);
         if (i == 31) check("grey_x31", pix_rgb, 16'h18E3);
         if (i == 45) check("grey_x5_y1", pix_rgb, 16'h0020);
         @(negedge vga_clk);
      end
      rst_n = 1'b0;
      #1;
      check("arst_de", vga_de, 0);
      check("arst_hs", vga_hs, 1);
      check("arst_rgb", pix_rgb, 0);
      check("arst_x", pix_x, 0);
      check("arst_fcnt", frame_cnt, 0);
      check("arst_rd", mem_rd_en, 0);
      @(negedge vga_clk);
      rst_n = 1'b1;
      @(negedge vga_clk);
      check("rel_fs_early", frame_start, 0);
      @(negedge vga_clk);
      check("rel_fs", frame_start, 1);
      check("rel_fcnt", frame_cnt, 1);

      // Enable drop at line 3: frame completes, then idle.
      for (int i = 0; i < 480; i++) begin
         if (i == 120) en = 1'b0;
         if (i == 400) check("drop_vs_active", vga_vs, 0);
         if (i == 479) check("drop_last_x", pix_x, 39);
         if (i == 479) check("drop_last_y", pix_y, 11);
         @(negedge vga_clk);
      end
      n_de = 0; n_hs = 0; n_vs = 0; n_fs = 0;
      for (int i = 0; i < 60; i++) begin
         if (vga_de)      n_de++;
         if (!vga_hs)     n_hs++;
         if (!vga_vs)     n_vs++;
         if (frame_start) n_fs++;
         @(negedge vga_clk);
      end
      check("idle_de", n_de, 0);
      check("idle_hs", n_hs, 0);
      check("idle_vs", n_vs, 0);
      check("idle_fs", n_fs, 0);
      check("idle_fcnt", frame_cnt, 1);
      check("idle_x", pix_x, 0);
      en = 1'b1;
      @(negedge vga_clk);
      check("reen_fs_early", frame_start, 0);
      @(negedge vga_clk);
      check("reen_fs", frame_start, 1);
      check("reen_fcnt", frame_cnt, 2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/vga_pattern_src.md
# vga_pattern_src

Synthesisable, parametrised VGA-timed pixel source for the OV5640 display path. Generates HS/VS/DE timing plus an RGB565 pixel stream from one of four selectable sources: an external image ROM (1-bit binary, e.g. Sobel output, or 16-bit RGB565), an 8-bar colour bar, a checkerboard, or a horizontal grey ramp. It replaces ad-hoc image-to-VGA benches. It feeds the VGA output stage directly or serves as a known-good stimulus for downstream image blocks.

## Interface
Parameters:
- H_ACTIVE, 640: active pixels per line
- H_FP, 16: horizontal front porch
- H_SYNC, 96: horizontal sync width
- H_BP, 48: horizontal back porch
- V_ACTIVE, 480: active lines per frame
- V_FP, 10: vertical front porch
- V_SYNC, 2: vertical sync width
- V_BP, 33: vertical back porch
- SYNC_POL, 0: active level of hs/vs
- IMG_W, 128: ROM image width
- IMG_H, 128: ROM image height
- ADDR_W, 14: ROM address width; requires 2^ADDR_W ≥ IMG_W*IMG_H
- MEM_W, 1: ROM word width; only 1 or 16 are legal
- CHK_SHIFT, 3: checker cell size is 2^CHK_SHIFT pixels

Ports:
- vga_clk, input, 1: pixel clock
- rst_n, input, 1: asynchronous, active-low reset
- en, input, 1: run enable
- mode, input, 2: source select. 0 = ROM, 1 = colour bar, 2 = checker, 3 = grey ramp
- mem_rd_en, output, 1: ROM read strobe
- mem_addr, output, ADDR_W: ROM address
- mem_rdata, input, MEM_W: ROM data, valid exactly 1 cycle after mem_rd_en
- vga_hs, output, 1: horizontal sync
- vga_vs, output, 1: vertical sync
- vga_de, output, 1: active video
- pix_x, output, 12: x coordinate of the current output pixel
- pix_y, output, 12: y coordinate of the current output pixel
- pix_rgb, output, 16: RGB565 pixel, {R[4:0], G[5:0], B[4:0]}
- frame_start, output, 1: one-cycle pulse that accompanies output pixel (0,0)
- frame_cnt, output, 16: completed-frame-start count

## Operation
- Counters:
  - h_cnt runs 0..H_TOTAL-1; v_cnt advances when h_cnt wraps.
  - Region order within each line/frame: active, then FP, then SYNC, then BP.
- Sync windows:
  - hs is active when h_cnt is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vs uses the same rule with the V parameters.
  - de = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- Enable:
  - While en=0 and the block is idle, counters are held at (0,0), sync outputs are inactive, and de=0.
  - en rising starts a frame at (0,0).
  - en falling mid-frame does not stop the block: the current frame completes through the end of its back porch, then the block idles.
- Mode latch: mode is sampled only at counter (0,0) of each frame. A mode change mid-frame takes effect on the next frame.
- Source behaviour (x = h_cnt, y = v_cnt):
  - mode 0, inside the image (x < IMG_W && y < IMG_H):
    - mem_rd_en=1 and mem_addr = y*IMG_W + x, computed with an incremental row-base register (no multiplier).
    - MEM_W=1: bit 1 gives 16'hFFFF, bit 0 gives 16'h0000.
    - MEM_W=16: mem_rdata passes through unchanged.
  - mode 0, outside the image: pixel is 16'h0000 and mem_rd_en=0.
  - mode 1: eight bars, each H_ACTIVE/8 wide, tracked by a bar counter (no divider).
    - Order: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
    - Any remainder columns take bar 7.
  - mode 2: pixel is FFFF when x[CHK_SHIFT]^y[CHK_SHIFT] = 1, else 0000.
  - mode 3: pixel is {x[7:3], x[7:2], x[7:3]}.
- Blanking: pix_rgb = 0 whenever de=0, in every mode.

## Timing
- Pipeline:
  - Stage 0: counters.
  - Stage 1: mem_addr/mem_rd_en registered, pattern and sync computed.
  - Stage 2: all video outputs registered.
- Latency: vga_hs, vga_vs, vga_de, pix_x, pix_y and pix_rgb are mutually aligned and lag the counters by exactly 2 cycles. mem_addr leads the corresponding pix_rgb by exactly 1 cycle.
- frame_start is high for one cycle, aligned with output pixel (0,0). frame_cnt increments in that same cycle and wraps from FFFF to 0000.
- Reset values (asynchronous assert, synchronous release):
  - Counters 0; vga_hs and vga_vs = ~SYNC_POL.
  - vga_de, pix_rgb, pix_x, pix_y, mem_rd_en, mem_addr, frame_start and frame_cnt all 0.
  - Reset mid-frame aborts immediately, with no partial-frame completion.
- Idle drain: after en falls, the 2-cycle pipeline drains, then all outputs hold their reset values except frame_cnt, which keeps its count.

## Test plan
Bench parameters: H_ACTIVE=32, H_FP=2, H_SYNC=4, H_BP=2, V_ACTIVE=8, V_FP=1, V_SYNC=2, V_BP=1, IMG_W=IMG_H=4.
- Timing check: en=1, mode=2 → line period 40 cycles, hs low for 4 cycles starting 34 cycles after de rises, frame period 480 cycles, de high for 32×8 pixels per frame.
- ROM binary image: mode=0, MEM_W=1, ROM loaded with a diagonal pattern → pix_rgb=FFFF exactly at (0,0), (1,1), (2,2), (3,3); 0000 elsewhere; mem_addr 5 issued one cycle before the (1,1) output.
- Colour bar: mode=1 → x=0..3 gives FFFF, x=4..7 gives FFE0, …, x=28..31 gives 0000; pix_rgb=0 during blanking.
- Mode change: mode switched from 1 to 3 mid-frame → the current frame stays colour bar; the next frame shows pix_rgb=0x0841 at x=8 (per {x[7:3], x[7:2], x[7:3]}).
- Enable drop: en deasserted at line 3 → the frame completes, frame_cnt=1, then vs/hs stay inactive and frame_start stays 0; re-asserting en gives frame_start 2 cycles later and frame_cnt=2.
- Async reset: rst_n pulsed low mid-line → outputs immediately take their reset values; the first frame_start appears 2 cycles after release, with frame_cnt=1.
